control_param_bank: RTL and testbench
=====================================

CONTROL_PARAM_BANK -- requirements
Module: control_param_bank

Interface
REQ-001 SHALL have parameter N_REGS, default 8, number of live parameter registers (1..256).
REQ-002 SHALL have parameter REG_W, default 48, bits per register (1..256).
REQ-003 SHALL have parameter CHUNK_W, default 16, payload bits per command (1..16); NCHUNK = ceil(REG_W/CHUNK_W), at most 16.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1024, idle cycles before a partial write is discarded.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 received_data  input  32  command word: [31:28] op, [27:20] reg index, [19:16] chunk index, [15:0] payload.
REQ-008 received_control_param_valid  input  1  command valid.
REQ-009 cmd_ready  output  1  command accepted when valid&&ready.
REQ-010 wipe_settings  input  1  synchronous clear of all state.
REQ-011 ack / nak / err  output  1 each  one-cycle response pulses.
REQ-012 timeout  output  1  one-cycle pulse when staging is discarded by timeout.
REQ-013 regs_flat  output  N_REGS*REG_W  live registers; reg i at [i*REG_W +: REG_W].
REQ-014 update_cmd  output  N_REGS  one-cycle pulse per committed register.
REQ-015 written  output  N_REGS  register committed at least once since reset/wipe.
REQ-016 all_written  output  1  &written.
REQ-017 rd_data  output  CHUNK_W  readback chunk; rd_valid  output  1  one-cycle qualifier.

Function
REQ-018 FSM SHALL have states IDLE, DECODE, RESPOND; IDLE->DECODE on valid&&ready; DECODE->RESPOND; RESPOND->IDLE, unconditionally.
REQ-019 cmd_ready SHALL be high only in IDLE; valid outside IDLE is ignored.
REQ-020 Exactly one of ack/nak/err SHALL pulse in RESPOND, two cycles after acceptance.
REQ-021 Ops: 1 WRITE, 2 READ, 3 CLEAR (equivalent to wipe_settings, then ack); other ops SHALL produce nak with no state change.
REQ-022 Reg index >= N_REGS or chunk index >= NCHUNK SHALL produce nak with no state change.
REQ-023 WRITE SHALL store payload[CHUNK_W-1:0] into a single staging buffer at chunk position, marking that chunk received; chunks in any order; a repeated chunk overwrites.
REQ-024 WRITE to a register different from the one currently staged SHALL discard old staging, start new staging with this chunk, and respond err instead of ack.
REQ-025 When all NCHUNK chunks are received, the register SHALL be committed: live value, update_cmd[i] and written[i] change on the edge entering RESPOND; update_cmd[i] high exactly that one cycle; staging cleared.
REQ-026 Bits of the top chunk beyond REG_W SHALL be discarded.
REQ-027 READ SHALL drive rd_data with the selected chunk of the live register (zero-padded) and pulse rd_valid with ack in RESPOND; staging is unaffected.
REQ-028 Timeout counter SHALL run while staging is non-empty, restart on each accepted WRITE, and at TIMEOUT_CYC discard staging and pulse timeout; acceptance of a WRITE on the expiry cycle wins (no timeout).
REQ-029 wipe_settings SHALL override an in-flight command: FSM to IDLE, no response pulse, registers/staging/written/counter zeroed next edge.
REQ-030 Outputs other than listed pulses SHALL hold value between commits.

Reset
REQ-031 reset low SHALL asynchronously force: FSM IDLE, cmd_ready 1 after release, regs_flat 0, update_cmd 0, written 0, all_written 0, ack/nak/err/timeout/rd_valid 0, rd_data 0, staging empty, counter 0.
REQ-032 Reset asserted mid-command SHALL abort it without a response after release.

Structure
REQ-033 Op codes, field bit positions and FSM state encodings SHALL live in shared package control_param_pkg.
REQ-034 Staging buffer, received-chunk mask and timeout counter SHALL form sub-module control_param_stager.

Verification (N_REGS=8, REG_W=48, CHUNK_W=16)
REQ-035 WRITE reg3 chunks 2,0,1 payloads 0xAAAA,0x1111,0x5555 -> three acks; after third, regs_flat[191:144]=0xAAAA55551111, update_cmd=0x08 for one cycle, written[3]=1.
REQ-036 WRITE reg1 chunk0, then WRITE reg2 chunk0 -> ack then err; reg1 unchanged; reg2 staging holds chunk0.
REQ-037 WRITE reg0 chunk0, idle 1024 cycles -> timeout pulse, no update_cmd; later READ reg0 chunk0 -> rd_data=0x0000.
REQ-038 op 7, or reg index 8, or chunk 3 -> nak, no state change; valid held during DECODE/RESPOND accepted only once.
REQ-039 Commit all 8 registers -> all_written=1; wipe_settings during DECODE -> no response, regs_flat=0, all_written=0.
REQ-040 reset low during RESPOND -> all outputs 0 immediately; no response after release.

Source files
------------

// File: rtl/control_param_pkg.sv
// Shared command-word layout, op codes and FSM encodings for the
// control parameter bank.
package control_param_pkg;

  localparam int CMD_W       = 32;
  localparam int OP_LSB      = 28;
  localparam int OP_W        = 4;
  localparam int REG_LSB     = 20;
  localparam int REG_IDX_W   = 8;
  localparam int CHUNK_LSB   = 16;
  localparam int CHUNK_IDX_W = 4;
  localparam int PAY_LSB     = 0;
  localparam int PAY_W       = 16;

  localparam logic [OP_W-1:0] OP_WRITE = 4'd1;
  localparam logic [OP_W-1:0] OP_READ  = 4'd2;
  localparam logic [OP_W-1:0] OP_CLEAR = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DECODE  = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RESP_ACK = 2'd0,
    RESP_NAK = 2'd1,
    RESP_ERR = 2'd2
  } resp_t;

  function automatic logic [OP_W-1:0] cmd_op(input logic [CMD_W-1:0] w);
    return w[OP_LSB +: OP_W];
  endfunction

  function automatic logic [REG_IDX_W-1:0] cmd_reg(input logic [CMD_W-1:0] w);
    return w[REG_LSB +: REG_IDX_W];
  endfunction

  function automatic logic [CHUNK_IDX_W-1:0] cmd_chunk(input logic [CMD_W-1:0] w);
    return w[CHUNK_LSB +: CHUNK_IDX_W];
  endfunction

  function automatic logic [PAY_W-1:0] cmd_payload(input logic [CMD_W-1:0] w);
    return w[PAY_LSB +: PAY_W];
  endfunction

endpackage

// File: rtl/control_param_stager.sv
// Single staging buffer for a partially written register: chunk data,
// received-chunk mask, owning register index and the idle timeout.
module control_param_stager
  import control_param_pkg::*;
#(
  parameter int CHUNK_W     = 16,
  parameter int NCHUNK      = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        wr_en,
  input  logic                        wr_fresh,
  input  logic [REG_IDX_W-1:0]        wr_reg,
  input  logic [CHUNK_IDX_W-1:0]      wr_chunk,
  input  logic [CHUNK_W-1:0]          wr_payload,
  input  logic                        restart,
  output logic [NCHUNK*CHUNK_W-1:0]   stage_data,
  output logic [NCHUNK-1:0]           stage_mask,
  output logic [REG_IDX_W-1:0]        stage_reg,
  output logic                        busy,
  output logic                        timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt;
  logic             expire;

  assign busy   = |stage_mask;
  // A WRITE accepted on the expiry cycle restarts the count instead of expiring.
  assign expire = busy && !restart && (cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_data <= '0;
      stage_mask <= '0;
      stage_reg  <= '0;
      cnt        <= '0;
      timeout    <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (flush) begin
        stage_data <= '0;
        stage_mask <= '0;
        stage_reg  <= '0;
        cnt        <= '0;
      end else if (wr_en) begin
        if (wr_fresh) begin
          stage_data <= '0;
          stage_mask <= '0;
        end
        for (int k = 0; k < NCHUNK; k++) begin
          if (wr_chunk == CHUNK_IDX_W'(k)) begin
            stage_data[k*CHUNK_W +: CHUNK_W] <= wr_payload;
            stage_mask[k]                    <= 1'b1;
          end
        end
        stage_reg <= wr_reg;
        cnt       <= '0;
      end else if (expire) begin
        stage_data <= '0;
        stage_mask <= '0;
        stage_reg  <= '0;
        cnt        <= '0;
        timeout    <= 1'b1;
      end else if (restart) begin
        cnt <= '0;
      end else if (busy) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/control_param_bank.sv
// Chunked control-parameter register bank: a command is accepted in IDLE,
// decoded, and answered by a single ack/nak/err pulse two cycles later.
module control_param_bank
  import control_param_pkg::*;
#(
  parameter int N_REGS      = 8,
  parameter int REG_W       = 48,
  parameter int CHUNK_W     = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CMD_W-1:0]          received_data,
  input  logic                      received_control_param_valid,
  output logic                      cmd_ready,
  input  logic                      wipe_settings,
  output logic                      ack,
  output logic                      nak,
  output logic                      err,
  output logic                      timeout,
  output logic [N_REGS*REG_W-1:0]   regs_flat,
  output logic [N_REGS-1:0]         update_cmd,
  output logic [N_REGS-1:0]         written,
  output logic                      all_written,
  output logic [CHUNK_W-1:0]        rd_data,
  output logic                      rd_valid
);

  localparam int NCHUNK = (REG_W + CHUNK_W - 1) / CHUNK_W;
  localparam int PAD_W  = NCHUNK * CHUNK_W;
  localparam int IDX_W  = (N_REGS > 1) ? $clog2(N_REGS) : 1;

  state_t                   state, state_next;
  logic [CMD_W-1:0]         cmd_q;
  logic                     accept, in_decode;
  logic [REG_W-1:0]         regs [N_REGS];

  logic [OP_W-1:0]          op;
  logic [REG_IDX_W-1:0]     ridx;
  logic [CHUNK_IDX_W-1:0]   cidx;
  logic [PAY_W-1:0]         payload_full;
  logic [CHUNK_W-1:0]       payload;
  logic [IDX_W-1:0]         sel;
  logic                     idx_ok, switch_reg, complete;
  logic [NCHUNK-1:0]        stage_mask, mask_next;
  logic [PAD_W-1:0]         stage_data, merged, padded;
  logic [REG_IDX_W-1:0]     stage_reg;
  logic                     stage_busy;
  resp_t                    resp;
  logic                     do_write, do_read, do_clear, do_commit;
  logic [N_REGS-1:0]        sel_onehot;
  logic [CHUNK_W-1:0]       rd_next;
  logic                     flush, wr_en, restart;

  assign cmd_ready   = (state == ST_IDLE) && reset;
  assign accept      = received_control_param_valid && cmd_ready && !wipe_settings;
  assign in_decode   = (state == ST_DECODE) && !wipe_settings;
  assign all_written = &written;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (accept) state_next = ST_DECODE;
      ST_DECODE:  state_next = ST_RESPOND;
      ST_RESPOND: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
    if (wipe_settings) state_next = ST_IDLE;
  end

  // Stage: accept -> decode
  always_ff @(posedge clk) begin
    if (accept) cmd_q <= received_data;
  end

  assign op           = cmd_op(cmd_q);
  assign ridx         = cmd_reg(cmd_q);
  assign cidx         = cmd_chunk(cmd_q);
  assign payload_full = cmd_payload(cmd_q);
  assign payload      = payload_full[CHUNK_W-1:0];
  assign sel          = ridx[IDX_W-1:0];
  assign idx_ok       = ({1'b0, ridx} < 9'(N_REGS)) && ({1'b0, cidx} < 5'(NCHUNK));

  always_comb begin
    resp       = RESP_NAK;
    do_write   = 1'b0;
    do_read    = 1'b0;
    do_clear   = 1'b0;
    switch_reg = stage_busy && (stage_reg != ridx);
    mask_next  = switch_reg ? '0 : stage_mask;
    merged     = switch_reg ? '0 : stage_data;
    for (int k = 0; k < NCHUNK; k++) begin
      if (cidx == CHUNK_IDX_W'(k)) begin
        mask_next[k]                 = 1'b1;
        merged[k*CHUNK_W +: CHUNK_W] = payload;
      end
    end
    complete = &mask_next;
    padded   = '0;
    padded[REG_W-1:0] = regs[sel];
    rd_next  = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (cidx == CHUNK_IDX_W'(k)) rd_next = padded[k*CHUNK_W +: CHUNK_W];
    end
    sel_onehot = '0;
    for (int i = 0; i < N_REGS; i++) sel_onehot[i] = (sel == IDX_W'(i));
    if (idx_ok) begin
      case (op)
        OP_WRITE: begin
          do_write = 1'b1;
          resp     = switch_reg ? RESP_ERR : RESP_ACK;
        end
        OP_READ: begin
          do_read = 1'b1;
          resp    = RESP_ACK;
        end
        OP_CLEAR: begin
          do_clear = 1'b1;
          resp     = RESP_ACK;
        end
        default: resp = RESP_NAK;
      endcase
    end
  end

  assign do_commit = do_write && complete;
  assign flush     = wipe_settings || (in_decode && (do_clear || do_commit));
  assign wr_en     = in_decode && do_write && !complete;
  assign restart   = accept && (cmd_op(received_data) == OP_WRITE);

  control_param_stager #(
    .CHUNK_W     (CHUNK_W),
    .NCHUNK      (NCHUNK),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_stager (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .wr_en      (wr_en),
    .wr_fresh   (switch_reg),
    .wr_reg     (ridx),
    .wr_chunk   (cidx),
    .wr_payload (payload),
    .restart    (restart),
    .stage_data (stage_data),
    .stage_mask (stage_mask),
    .stage_reg  (stage_reg),
    .busy       (stage_busy),
    .timeout    (timeout)
  );

  // Stage: decode -> respond
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack        <= 1'b0;
      nak        <= 1'b0;
      err        <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      update_cmd <= '0;
      written    <= '0;
      for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
    end else begin
      ack        <= 1'b0;
      nak        <= 1'b0;
      err        <= 1'b0;
      rd_valid   <= 1'b0;
      update_cmd <= '0;
      if (in_decode) begin
        ack <= (resp == RESP_ACK);
        nak <= (resp == RESP_NAK);
        err <= (resp == RESP_ERR);
      end
      if (wipe_settings || (in_decode && do_clear)) begin
        rd_data <= '0;
        written <= '0;
        for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
      end else if (in_decode) begin
        if (do_commit) begin
          for (int i = 0; i < N_REGS; i++) begin
            if (sel_onehot[i]) regs[i] <= merged[REG_W-1:0];
          end
          update_cmd <= sel_onehot;
          written    <= written | sel_onehot;
        end
        if (do_read) begin
          rd_data  <= rd_next;
          rd_valid <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < N_REGS; i++) regs_flat[i*REG_W +: REG_W] = regs[i];
  end

endmodule

// File: tb/tb_control_param_bank.sv
// Directed bench for control_param_bank with a register/staging model
// compared against the live outputs every cycle.
module tb_control_param_bank;

  localparam int TIMEOUT_CYC = 1024;
  localparam logic [3:0] WR  = 4'd1;
  localparam logic [3:0] RD  = 4'd2;
  localparam logic [3:0] CLR = 4'd3;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  received_data;
  logic         received_control_param_valid;
  logic         cmd_ready;
  logic         wipe_settings;
  logic         ack, nak, err, timeout;
  logic [383:0] regs_flat;
  logic [7:0]   update_cmd, written;
  logic         all_written;
  logic [15:0]  rd_data;
  logic         rd_valid;

  control_param_bank #(
    .N_REGS(8), .REG_W(48), .CHUNK_W(16), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk                          (clk),
    .reset                        (reset),
    .received_data                (received_data),
    .received_control_param_valid (received_control_param_valid),
    .cmd_ready                    (cmd_ready),
    .wipe_settings                (wipe_settings),
    .ack                          (ack),
    .nak                          (nak),
    .err                          (err),
    .timeout                      (timeout),
    .regs_flat                    (regs_flat),
    .update_cmd                   (update_cmd),
    .written                      (written),
    .all_written                  (all_written),
    .rd_data                      (rd_data),
    .rd_valid                     (rd_valid)
  );

  always #5 clk = ~clk;

  int n_pass, n_total;
  bit chk_en;

  // Model: live registers, written flags and the one staging buffer.
  logic [47:0] m_regs [8];
  logic [7:0]  m_written;
  int          m_stg_reg;
  logic [15:0] m_stg [3];
  logic [2:0]  m_mask;

  logic [2:0]  rs;
  logic [7:0]  us;
  logic [15:0] ds;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_written = '0;
    m_stg_reg = -1;
    m_mask    = '0;
    m_stg     = '{default: '0};
  endtask

  // resp is {ack, nak, err}
  task automatic model_cmd(input logic [3:0] op, input int r, input int c, input logic [15:0] pay,
                           output logic [2:0] resp, output logic [7:0] upd,
                           output logic rv, output logic [15:0] rd);
    resp = 3'b010; upd = '0; rv = 1'b0; rd = '0;
    if (r >= 8 || c >= 3) return;
    if (op == WR) begin
      resp = (m_stg_reg >= 0 && m_stg_reg != r) ? 3'b001 : 3'b100;
      if (m_stg_reg != r) begin
        m_mask = '0;
        m_stg  = '{default: '0};
      end
      m_stg_reg  = r;
      m_stg[c]   = pay;
      m_mask[c]  = 1'b1;
      if (m_mask == 3'b111) begin
        m_regs[r]    = {m_stg[2], m_stg[1], m_stg[0]};
        m_written[r] = 1'b1;
        upd[r]       = 1'b1;
        m_stg_reg    = -1;
        m_mask       = '0;
      end
    end else if (op == RD) begin
      resp = 3'b100;
      rv   = 1'b1;
      rd   = m_regs[r][c*16 +: 16];
    end else if (op == CLR) begin
      resp = 3'b100;
      model_clear();
    end
  endtask

  task automatic send(input string name, input logic [3:0] op, input int r, input int c,
                      input logic [15:0] pay, input bit hold,
                      output logic [2:0] rso, output logic [7:0] uso, output logic [15:0] dso);
    logic [2:0]  e_resp;
    logic [7:0]  e_upd;
    logic        e_rv;
    logic [15:0] e_rd;
    @(negedge clk);
    chk({name, "/ready"}, cmd_ready, 1);
    received_data = {op, 8'(r), 4'(c), pay};
    received_control_param_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) received_control_param_valid = 1'b0;
    chk({name, "/busy"}, cmd_ready, 0);
    @(posedge clk);
    model_cmd(op, r, c, pay, e_resp, e_upd, e_rv, e_rd);
    @(negedge clk);
    rso = {ack, nak, err};
    uso = update_cmd;
    dso = rd_data;
    chk({name, "/resp"}, rso, e_resp);
    chk({name, "/update"}, uso, e_upd);
    chk({name, "/rd_valid"}, rd_valid, e_rv);
    if (e_rv) chk({name, "/rd_data"}, rd_data, e_rd);
    received_control_param_valid = 1'b0;
    @(negedge clk);
    chk({name, "/after"}, {ack, nak, err, rd_valid, update_cmd, cmd_ready}, {12'd0, 1'b1});
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < 8; i++)
          chk($sformatf("live_reg%0d", i), regs_flat[i*48 +: 48], m_regs[i]);
        chk("written", written, m_written);
        chk("all_written", all_written, &m_written);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  saw_upd;
    n_pass = 0; n_total = 0; chk_en = 1'b0;
    reset = 1'b0; received_data = '0; received_control_param_valid = 1'b0; wipe_settings = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_outputs", {ack, nak, err, timeout, rd_valid, update_cmd, written, all_written}, 0);
    chk("rst_regs", |regs_flat, 0);
    chk("rst_rd_data", rd_data, 0);

    // Out-of-order chunk writes complete register 3.
    send("w3c2", WR, 3, 2, 16'hAAAA, 0, rs, us, ds);
    chk("w3c2_ack", rs, 3'b100);
    send("w3c0", WR, 3, 0, 16'h1111, 0, rs, us, ds);
    send("w3c1", WR, 3, 1, 16'h5555, 0, rs, us, ds);
    chk("w3_commit_upd", us, 8'h08);
    chk("w3_value", regs_flat[191:144], 48'hAAAA55551111);
    chk("w3_written", written[3], 1);

    // Partial write left idle is discarded by the timeout.
    send("to_w0", WR, 0, 0, 16'hBEEF, 0, rs, us, ds);
    saw_upd = 1'b0;
    n = 0;
    while (n < TIMEOUT_CYC + 50) begin
      @(negedge clk);
      n++;
      if (update_cmd != 0) saw_upd = 1'b1;
      if (timeout) break;
    end
    chk("to_latency_window", (n >= TIMEOUT_CYC - 3) && (n <= TIMEOUT_CYC + 1), 1);
    chk("to_pulse", timeout, 1);
    chk("to_no_update", saw_upd, 0);
    m_stg_reg = -1;
    m_mask    = '0;
    @(negedge clk);
    chk("to_one_cycle", timeout, 0);
    send("to_rd0", RD, 0, 0, 16'h0, 0, rs, us, ds);
    chk("to_rd0_data", ds, 16'h0000);

    // Switching registers mid-staging discards the old one with err.
    send("sw_w1", WR, 1, 0, 16'h1234, 0, rs, us, ds);
    chk("sw_w1_ack", rs, 3'b100);
    send("sw_w2", WR, 2, 0, 16'h2222, 0, rs, us, ds);
    chk("sw_w2_err", rs, 3'b001);
    chk("sw_reg1_kept", regs_flat[95:48], 48'h0);
    send("sw_w2c1", WR, 2, 1, 16'h3333, 0, rs, us, ds);
    send("sw_w2c2", WR, 2, 2, 16'h4444, 0, rs, us, ds);
    chk("sw_reg2_value", regs_flat[143:96], 48'h444433332222);
    send("sw_rd2", RD, 2, 1, 16'h0, 0, rs, us, ds);
    chk("sw_rd2_data", ds, 16'h3333);

    // Illegal op / index produce nak; valid held through the command.
    send("bad_op", 4'd7, 0, 0, 16'hFFFF, 1, rs, us, ds);
    chk("bad_op_nak", rs, 3'b010);
    send("bad_reg", WR, 8, 0, 16'hFFFF, 1, rs, us, ds);
    chk("bad_reg_nak", rs, 3'b010);
    send("bad_chunk", WR, 1, 3, 16'hFFFF, 1, rs, us, ds);
    chk("bad_chunk_nak", rs, 3'b010);

    // Commit every register.
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 3; c++)
        send($sformatf("all_r%0dc%0d", r, c), WR, r, c, 16'(r * 4096 + c * 256 + 165), 0, rs, us, ds);
    chk("all_written_full", all_written, 1);
    chk("written_full", written, 8'hFF);
    send("all_rd7", RD, 7, 2, 16'h0, 0, rs, us, ds);
    chk("all_rd7_data", ds, 16'h72A5);

    // wipe_settings during DECODE suppresses the response.
    @(negedge clk);
    received_data = {RD, 8'd7, 4'd2, 16'h0};
    received_control_param_valid = 1'b1;
    @(posedge clk);
    #1;
    received_control_param_valid = 1'b0;
    wipe_settings = 1'b1;
    @(posedge clk);
    model_clear();
    #1;
    wipe_settings = 1'b0;
    @(negedge clk);
    chk("wipe_no_resp", {ack, nak, err, rd_valid}, 0);
    chk("wipe_idle", cmd_ready, 1);
    chk("wipe_regs", |regs_flat, 0);
    chk("wipe_all_written", all_written, 0);

    // CLEAR op wipes committed state and acks.
    for (int c = 0; c < 3; c++)
      send($sformatf("clr_w5c%0d", c), WR, 5, c, 16'h5A00 + 16'(c), 0, rs, us, ds);
    chk("clr_pre_written", written, 8'h20);
    send("clr_op", CLR, 0, 0, 16'h0, 0, rs, us, ds);
    chk("clr_ack", rs, 3'b100);
    chk("clr_written", written, 0);
    chk("clr_regs", |regs_flat, 0);

    // Reset asserted during RESPOND of a committing write.
    send("rst_w6c0", WR, 6, 0, 16'h6000, 0, rs, us, ds);
    send("rst_w6c1", WR, 6, 1, 16'h6001, 0, rs, us, ds);
    @(negedge clk);
    received_data = {WR, 8'd6, 4'd2, 16'h6002};
    received_control_param_valid = 1'b1;
    @(posedge clk);
    #1;
    received_control_param_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("rst_mid_update", update_cmd, 8'h40);
    reset = 1'b0;
    model_clear();
    #1;
    chk("rst_mid_pulses", {ack, nak, err, timeout, rd_valid}, 0);
    chk("rst_mid_state", {update_cmd, written, all_written}, 0);
    chk("rst_mid_regs", |regs_flat, 0);
    chk("rst_mid_rd_data", rd_data, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_quiet", {ack, nak, err, rd_valid, update_cmd, cmd_ready}, {12'd0, 1'b1});
    end
    send("post_rst_w6", WR, 6, 0, 16'h0606, 0, rs, us, ds);
    chk("post_rst_ack", rs, 3'b100);

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
